// File: rtl/mac_bank_acc.sv
// Bank of NUM_LANE 3x3 convolution MAC lanes (4x4 patch -> 2x2 tile) with saturating cross-beat accumulation.
// Optional build macro MAC_BANK_ACC_RELU_EN clamps registered outputs to >= 0.
module mac_bank_acc #(
    parameter int NUM_LANE = 12,
    parameter int DW       = 8,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 20,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          iVld,
    input  logic                          iFirst,
    input  logic                          iLast,
    input  logic                          iClr,
    input  logic [NUM_LANE*16*DW-1:0]     iDin,
    input  logic [NUM_LANE*9*DW-1:0]      iWeight,
    output logic [NUM_LANE*4*OUT_W-1:0]   oOut,
    output logic                          oVld,
    output logic                          oVld_pre,
    output logic                          oBusy,
    output logic [CNT_W-1:0]              oCnt,
    output logic                          oErr
);

    localparam int PW  = 2*DW;
    localparam int SW  = 2*DW+4;
    localparam int AW1 = ACC_W+1;

    // state    | meaning
    // ST_IDLE  | no tile open; next beat starts a fresh accumulation
    // ST_ACC   | tile open; beats add onto the running accumulator
    typedef enum logic {ST_IDLE, ST_ACC} tile_st_e;

    tile_st_e                   st_q;

    logic                       s1_vld_q, s1_first_q, s1_last_q;
    logic                       s2_vld_q, s2_first_q, s2_last_q;
    logic signed [PW-1:0]       prod_d [NUM_LANE][4][9];
    logic signed [PW-1:0]       prod_q [NUM_LANE][4][9];
    logic signed [SW-1:0]       sum_d  [NUM_LANE][4];
    logic signed [SW-1:0]       sum_q  [NUM_LANE][4];
    logic signed [ACC_W-1:0]    acc_d  [NUM_LANE][4];
    logic signed [ACC_W-1:0]    acc_q  [NUM_LANE][4];
    logic [NUM_LANE*4*OUT_W-1:0] out_d, out_q;
    logic [CNT_W-1:0]           cnt_d, cnt_q;
    logic                       vld_q, vld_pre_q, err_q;
    logic                       start, err_d;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [AW1-1:0] v);
        logic signed [AW1-1:0] hi, lo;
        hi = $signed({2'b00, {(ACC_W-1){1'b1}}});
        lo = $signed({2'b11, {(ACC_W-1){1'b0}}});
        if (v > hi)      return hi[ACC_W-1:0];
        else if (v < lo) return lo[ACC_W-1:0];
        else             return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi, lo;
        hi = $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
        lo = $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
`ifdef MAC_BANK_ACC_RELU_EN
        if (v < 0)       return '0;
`endif
        if (v > hi)      return hi[OUT_W-1:0];
        else if (v < lo) return lo[OUT_W-1:0];
        else             return v[OUT_W-1:0];
    endfunction

    // Output j=(oy,ox) uses pixel (oy+r, ox+c) against tap (r,c).
    always_comb begin
        for (int l = 0; l < NUM_LANE; l++) begin
            for (int j = 0; j < 4; j++) begin
                for (int t = 0; t < 9; t++) begin
                    prod_d[l][j][t] =
                        PW'($signed(iDin[l*16*DW + (((j/2)+(t/3))*4 + (j%2)+(t%3))*DW +: DW])) *
                        PW'($signed(iWeight[l*9*DW + t*DW +: DW]));
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANE; l++) begin
            for (int j = 0; j < 4; j++) begin
                sum_d[l][j] = '0;
                for (int t = 0; t < 9; t++) begin
                    sum_d[l][j] = sum_d[l][j] + SW'(prod_q[l][j][t]);
                end
            end
        end
    end

    // A non-first beat on an idle bank is treated as a tile start (and flagged).
    always_comb begin
        start = s2_first_q | (st_q == ST_IDLE);
        err_d = s2_first_q ? (st_q == ST_ACC) : (st_q == ST_IDLE);
        cnt_d = start ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
        out_d = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            for (int j = 0; j < 4; j++) begin
                acc_d[l][j] = sat_acc((start ? AW1'(0) : AW1'(acc_q[l][j])) + AW1'(sum_q[l][j]));
                out_d[(l*4+j)*OUT_W +: OUT_W] = sat_out(acc_d[l][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q       <= ST_IDLE;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            out_q      <= '0;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
            vld_pre_q  <= 1'b0;
            err_q      <= 1'b0;
            for (int l = 0; l < NUM_LANE; l++) begin
                for (int j = 0; j < 4; j++) begin
                    sum_q[l][j] <= '0;
                    acc_q[l][j] <= '0;
                    for (int t = 0; t < 9; t++) prod_q[l][j][t] <= '0;
                end
            end
        end else if (iClr) begin
            st_q      <= ST_IDLE;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            cnt_q     <= '0;
            vld_q     <= 1'b0;
            vld_pre_q <= 1'b0;
            err_q     <= 1'b0;
            for (int l = 0; l < NUM_LANE; l++) begin
                for (int j = 0; j < 4; j++) acc_q[l][j] <= '0;
            end
        end else begin
            s1_vld_q  <= iVld;
            s2_vld_q  <= s1_vld_q;
            vld_pre_q <= s1_vld_q & s1_last_q;
            vld_q     <= s2_vld_q & s2_last_q;
            if (iVld) begin
                prod_q     <= prod_d;
                s1_first_q <= iFirst;
                s1_last_q  <= iLast;
            end
            if (s1_vld_q) begin
                sum_q      <= sum_d;
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
            end
            if (s2_vld_q) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                st_q  <= s2_last_q ? ST_IDLE : ST_ACC;
                if (err_d)     err_q <= 1'b1;
                if (s2_last_q) out_q <= out_d;
            end
        end
    end

    assign oOut     = out_q;
    assign oVld     = vld_q;
    assign oVld_pre = vld_pre_q;
    assign oBusy    = (st_q == ST_ACC);
    assign oCnt     = cnt_q;
    assign oErr     = err_q;

endmodule

// File: tb/tb_mac_bank_acc.sv
// Directed bench for mac_bank_acc: framing, saturation, back-to-back tiles, errors, abort and reset.
module tb_mac_bank_acc;

    localparam int NL    = 12;
    localparam int DW    = 8;
    localparam int OUT_W = 20;
    localparam int CNT_W = 8;

    logic                    clk;
    logic                    rstn;
    logic                    iVld, iFirst, iLast, iClr;
    logic [NL*16*DW-1:0]     iDin;
    logic [NL*9*DW-1:0]      iWeight;
    logic [NL*4*OUT_W-1:0]   oOut;
    logic                    oVld, oVld_pre, oBusy, oErr;
    logic [CNT_W-1:0]        oCnt;

    int checks = 0;
    int errors = 0;

    mac_bank_acc dut (
        .clk      (clk),
        .rstn     (rstn),
        .iVld     (iVld),
        .iFirst   (iFirst),
        .iLast    (iLast),
        .iClr     (iClr),
        .iDin     (iDin),
        .iWeight  (iWeight),
        .oOut     (oOut),
        .oVld     (oVld),
        .oVld_pre (oVld_pre),
        .oBusy    (oBusy),
        .oCnt     (oCnt),
        .oErr     (oErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] get_out(input int l, input int j);
        logic signed [OUT_W-1:0] v;
        v = oOut[(l*4+j)*OUT_W +: OUT_W];
        return v;
    endfunction

    task automatic chk_tile(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int l = 0; l < NL; l++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s_l%0d_j%0d", tag, l, j), get_out(l, j), e[j]);
    endtask

    task automatic chk_flags(input string tag, input int vld, input int pre, input int busy, input int cnt, input int err);
        chk({tag, "_vld"},  oVld,     vld);
        chk({tag, "_pre"},  oVld_pre, pre);
        chk({tag, "_busy"}, oBusy,    busy);
        chk({tag, "_cnt"},  oCnt,     cnt);
        chk({tag, "_err"},  oErr,     err);
    endtask

    task automatic set_all(input logic [7:0] x, input logic [7:0] w);
        for (int l = 0; l < NL; l++) begin
            for (int p = 0; p < 16; p++) iDin[(l*16+p)*DW +: DW] = x;
            for (int t = 0; t < 9; t++)  iWeight[(l*9+t)*DW +: DW] = w;
        end
    endtask

    // x[r][c] = r*4+c; lane weights chosen by caller via tap index and value
    task automatic set_ramp_tap(input int lane_var, input logic [7:0] wv);
        for (int l = 0; l < NL; l++) begin
            for (int p = 0; p < 16; p++) iDin[(l*16+p)*DW +: DW] = 8'(p);
            for (int t = 0; t < 9; t++)
                iWeight[(l*9+t)*DW +: DW] = (t == (lane_var ? (l % 9) : 4)) ? wv : 8'd0;
        end
    endtask

    task automatic beat(input logic f, input logic l);
        iVld = 1'b1; iFirst = f; iLast = l;
        tick();
        iVld = 1'b0; iFirst = 1'b0; iLast = 1'b0;
    endtask

    initial begin
        rstn = 1'b1; iVld = 1'b0; iFirst = 1'b0; iLast = 1'b0; iClr = 1'b0;
        iDin = '0; iWeight = '0;
        #3 rstn = 1'b0;
        #1;
        chk_flags("rst", 0, 0, 0, 0, 0);
        chk("rst_out_l0", get_out(0, 0), 0);
        chk("rst_out_l11", get_out(NL-1, 3), 0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // three-beat tile of ones
        set_all(8'd1, 8'd1);
        beat(1, 0); beat(0, 0); beat(0, 1);
        chk_flags("t1_e2", 0, 0, 1, 1, 0);
        tick();
        chk_flags("t1_e3", 0, 1, 1, 2, 0);
        tick();
        chk_flags("t1_e4", 1, 0, 0, 3, 0);
        chk_tile("t1", 27, 27, 27, 27);
        tick();
        chk("t1_vld_pulse", oVld, 0);
        chk("t1_hold", get_out(5, 2), 27);

        // single-beat tile, centre tap = 2
        set_ramp_tap(0, 8'd2);
        beat(1, 1);
        chk("t2_busy_e2", oBusy, 0);
        tick(); tick();
        chk_flags("t2", 1, 0, 0, 1, 0);
        chk_tile("t2", 10, 12, 18, 20);

        // per-lane single tap (lane l uses tap l%9)
        set_ramp_tap(1, 8'd1);
        beat(1, 1);
        tick(); tick();
        chk("t2b_vld", oVld, 1);
        for (int l = 0; l < NL; l++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("t2b_l%0d_j%0d", l, j), get_out(l, j),
                    ((j/2) + (l%9)/3)*4 + (j%2) + (l%9)%3);

        // positive and negative saturation over 4 beats
        set_all(8'd127, 8'd127);
        beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 1);
        tick(); tick();
        chk_flags("t3p", 1, 0, 0, 4, 0);
        chk_tile("t3p", 524287, 524287, 524287, 524287);
        set_all(8'h80, 8'd127);
        beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 1);
        tick(); tick();
        chk("t3n_vld", oVld, 1);
`ifdef MAC_BANK_ACC_RELU_EN
        chk_tile("t3n", 0, 0, 0, 0);
`else
        chk_tile("t3n", -524288, -524288, -524288, -524288);
`endif

        // back-to-back two-beat tiles, no bubbles
        set_all(8'd1, 8'd1);
        iVld = 1'b1; iFirst = 1'b1; iLast = 1'b0; tick();
        iFirst = 1'b0; iLast = 1'b1; tick();
        chk("t4_a_vld", oVld, 0);
        chk("t4_a_pre", oVld_pre, 0);
        set_all(8'd2, 8'd1);
        iFirst = 1'b1; iLast = 1'b0; tick();
        chk("t4_b_pre", oVld_pre, 1);
        chk("t4_b_vld", oVld, 0);
        iFirst = 1'b0; iLast = 1'b1; tick();
        iVld = 1'b0; iLast = 1'b0;
        chk("t4_c_vld", oVld, 1);
        chk("t4_c_pre", oVld_pre, 0);
        chk_tile("t4_c", 18, 18, 18, 18);
        tick();
        chk("t4_d_vld", oVld, 0);
        chk("t4_d_pre", oVld_pre, 1);
        tick();
        chk_flags("t4_e", 1, 0, 0, 2, 0);
        chk_tile("t4_e", 36, 36, 36, 36);

        // framing errors
        set_all(8'd1, 8'd1);
        beat(0, 0);
        tick(); tick();
        chk_flags("t5_orphan", 0, 0, 1, 1, 1);
        beat(0, 0); beat(0, 1);
        tick(); tick();
        chk_flags("t5_tile", 1, 0, 0, 3, 1);
        chk_tile("t5_tile", 27, 27, 27, 27);
        beat(1, 0);
        set_all(8'd2, 8'd1);
        beat(1, 0); beat(0, 1);
        tick(); tick();
        chk_flags("t5_restart", 1, 0, 0, 2, 1);
        chk_tile("t5_restart", 36, 36, 36, 36);

        // abort with beats in flight, plus a beat coincident with iClr
        set_all(8'd1, 8'd1);
        beat(1, 0); beat(0, 0); beat(0, 1);
        chk("t6_busy_pre_clr", oBusy, 1);
        iClr = 1'b1; iVld = 1'b1; iFirst = 1'b1; iLast = 1'b1;
        tick();
        iClr = 1'b0; iVld = 1'b0; iFirst = 1'b0; iLast = 1'b0;
        chk_flags("t6_clr", 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_quiet_vld%0d", k), oVld, 0);
            chk($sformatf("t6_quiet_pre%0d", k), oVld_pre, 0);
        end
        chk("t6_out_kept", get_out(3, 1), 36);

        // async reset mid-tile with an error outstanding
        beat(0, 0);
        tick(); tick();
        chk_flags("t7_pre_rst", 0, 0, 1, 1, 1);
        #2 rstn = 1'b0;
        #1;
        chk_flags("t7_rst", 0, 0, 0, 0, 0);
        chk("t7_out", get_out(0, 0), 0);
        tick();
        rstn = 1'b1;
        tick();
        beat(1, 1);
        tick(); tick();
        chk_flags("t7_after", 1, 0, 0, 1, 0);
        chk("t7_after_out", get_out(NL-1, 0), 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
